// File: rtl/sram_arbiter.sv
// Two-port valid/ready arbiter and pin sequencer for an asynchronous 16Kx8 SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [1:0]          req_we_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic [1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                sram_cs_n_o,
  output logic                sram_we_n_o,
  output logic                sram_oe_n_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe_o,
  input  logic [DATA_W-1:0]   sram_dq_i,
  output logic [2:0]          dbg_state_o
);

  // Handshake: a request transfers in the cycle where req_valid_i[p] & req_ready_o[p];
  // the requester holds valid and payload stable until then.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_last;
  logic                gnt;
  logic                gnt_q;
  logic                hs;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign cnt_last    = (cnt == CNT_LAST);
  assign dbg_state_o = state;
  assign sel_we      = gnt ? req_we_i[1] : req_we_i[0];
  assign sel_addr    = gnt ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
  assign sel_wdata   = gnt ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];

`ifdef SRAM_ARB_RR_EN
  logic last_gnt;

  always_comb begin
    if (&req_valid_i) gnt = ~last_gnt;
    else              gnt = ~req_valid_i[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)   last_gnt <= 1'b1;
    else if (hs) last_gnt <= gnt;
  end
`else
  always_comb begin
    gnt = ~req_valid_i[0];
  end
`endif

  always_comb begin
    state_n     = state;
    req_ready_o = 2'b00;
    hs          = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rst_i) begin
          req_ready_o = gnt ? {req_valid_i[1], 1'b0} : {1'b0, req_valid_i[0]};
        end
        hs = |(req_ready_o & req_valid_i);
        if (hs) state_n = sel_we ? S_WR_SETUP : S_RD;
      end
      S_RD:       if (cnt_last) state_n = S_IDLE;
      S_WR_SETUP: state_n = S_WR_PULSE;
      S_WR_PULSE: if (cnt_last) state_n = S_WR_HOLD;
      S_WR_HOLD:  state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Pin flops are loaded from the next state so strobes line up with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      gnt_q        <= 1'b0;
      sram_cs_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_dq_oe_o <= 1'b0;
      sram_addr_o  <= '0;
      sram_dq_o    <= '0;
      rsp_valid_o  <= 2'b00;
      rsp_rdata_o  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= (state_n != state) ? '0 : cnt + 1'b1;
      sram_cs_n_o  <= (state_n == S_IDLE);
      sram_oe_n_o  <= (state_n != S_RD);
      sram_we_n_o  <= (state_n != S_WR_PULSE);
      sram_dq_oe_o <= (state_n == S_WR_SETUP) || (state_n == S_WR_PULSE) ||
                      (state_n == S_WR_HOLD);
      if (hs) begin
        gnt_q       <= gnt;
        sram_addr_o <= sel_addr;
        sram_dq_o   <= sel_wdata;
      end
      rsp_valid_o <= 2'b00;
      if (((state == S_RD) && cnt_last) || (state == S_WR_HOLD)) begin
        rsp_valid_o[gnt_q] <= 1'b1;
      end
      if ((state == S_RD) && cnt_last) begin
        rsp_rdata_o <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, per-scenario tasks, response scoreboard.
module tb_sram_arbiter #(
  parameter int WC = 1
);
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, sram_dq_o, sram_dq_i;
  logic [AW-1:0] sram_addr;
  logic          cs_n, we_n, oe_n, dq_oe;
  logic [2:0]    dbg_state;

  assign req_valid = {v1, v0};
  assign req_we    = {we1, we0};
  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sram_cs_n_o(cs_n), .sram_we_n_o(we_n), .sram_oe_n_o(oe_n),
    .sram_addr_o(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe_o(dq_oe),
    .sram_dq_i(sram_dq_i), .dbg_state_o(dbg_state)
  );

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Behavioural SRAM: drives read data only while selected with OE_N low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
  always @(posedge clk) if (!cs_n && !we_n) mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = (!cs_n && !oe_n) ? mem[sram_addr] : 'x;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]    exp_q[$];
  int            exp_t[$];
  int            gnt_log[$], hs_log[$], rsp_log[$];
  logic [7:0]    ref_mem[int];
  logic [7:0]    last_rd = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  int            we_lo = 0, oe_lo = 0, dq_cnt = 0;
  logic [9:0]    m_e;
  int            m_t;

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  // Monitor: pin invariants, strobe widths, response checks and handshake capture.
  always @(negedge clk) begin
    if (rst) begin
      we_lo = 0; oe_lo = 0; dq_cnt = 0;
    end else begin
      total++;
      if (!we_n && !oe_n) begin
        bad++; $display("FAIL we_oe_overlap cyc=%0d got we_n=0 oe_n=0 want not both 0", cyc);
      end
      total++;
      if (dq_oe && !oe_n) begin
        bad++; $display("FAIL dq_contention cyc=%0d got dq_oe=1 oe_n=0 want dq_oe=0", cyc);
      end
      if (!cs_n) begin
        total++;
        if (sram_addr !== cur_addr) begin
          bad++; $display("FAIL addr_stable cyc=%0d got %h want %h", cyc, sram_addr, cur_addr);
        end
        if (dq_oe) begin
          total++;
          if (sram_dq_o !== cur_data) begin
            bad++; $display("FAIL dq_stable cyc=%0d got %h want %h", cyc, sram_dq_o, cur_data);
          end
        end
      end
      if (!we_n) we_lo++;
      else if (we_lo > 0) begin
        total++;
        if (we_lo != WC + 1) begin
          bad++; $display("FAIL we_width got %0d want %0d", we_lo, WC + 1);
        end
        we_lo = 0;
      end
      if (!oe_n) oe_lo++;
      else if (oe_lo > 0) begin
        total++;
        if (oe_lo != WC + 1) begin
          bad++; $display("FAIL oe_width got %0d want %0d", oe_lo, WC + 1);
        end
        oe_lo = 0;
      end
      if (dq_oe) dq_cnt++;
      else if (dq_cnt > 0) begin
        total++;
        if (dq_cnt != WC + 3) begin
          bad++; $display("FAIL dq_oe_width got %0d want %0d", dq_cnt, WC + 3);
        end
        dq_cnt = 0;
      end
      if (rsp_valid !== 2'b00) begin
        rsp_log.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_rsp cyc=%0d got %b want 00", cyc, rsp_valid);
        end else begin
          m_e = exp_q.pop_front();
          m_t = exp_t.pop_front();
          if (rsp_valid !== (m_e[9] ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rsp_port got %b want port %0d", rsp_valid, m_e[9]);
          end
          total++;
          if (cyc != m_t) begin
            bad++; $display("FAIL rsp_latency got cyc %0d want cyc %0d", cyc, m_t);
          end
          total++;
          if (!m_e[8]) begin
            if (rsp_rdata !== m_e[7:0]) begin
              bad++; $display("FAIL rdata got %h want %h", rsp_rdata, m_e[7:0]);
            end
            last_rd = m_e[7:0];
          end else if (rsp_rdata !== last_rd) begin
            bad++; $display("FAIL rdata_hold got %h want %h", rsp_rdata, last_rd);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          gnt_log.push_back(p);
          hs_log.push_back(cyc);
          cur_addr = p ? a1 : a0;
          cur_data = p ? d1 : d0;
          if (req_we[p]) begin
            ref_mem[int'(cur_addr)] = cur_data;
            exp_q.push_back({p[0], 1'b1, 8'h00});
            exp_t.push_back(cyc + WC + 4);
          end else begin
            exp_q.push_back({p[0], 1'b0, ref_rd(cur_addr)});
            exp_t.push_back(cyc + WC + 2);
          end
        end
      end
    end
  end

  task automatic drive_op(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit keep);
    int n;
    bit got;
    if (p == 0) begin v0 = 1'b1; we0 = we; a0 = a; d0 = d; end
    else        begin v1 = 1'b1; we1 = we; a1 = a; d1 = d; end
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (req_valid[p] && req_ready[p]) got = 1'b1;
      n++;
    end
    if (!got) begin
      total++; bad++; $display("FAIL handshake_timeout port=%0d got none want accept", p);
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (p == 0) v0 = 1'b0; else v1 = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++; $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v0 = 1'b1; we0 = 1'b0; a0 = 14'h0055;
    v1 = 1'b1; we1 = 1'b1; a1 = 14'h0066; d1 = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got %b want 00", req_ready); end
    total++;
    if ({cs_n, we_n, oe_n, dq_oe} !== 4'b1110) begin
      bad++; $display("FAIL reset_ctrl got %b want 1110", {cs_n, we_n, oe_n, dq_oe});
    end
    total++;
    if (sram_addr !== '0 || sram_dq_o !== '0) begin
      bad++; $display("FAIL reset_bus got %h/%h want 0/0", sram_addr, sram_dq_o);
    end
    total++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== '0) begin
      bad++; $display("FAIL reset_rsp got %b/%h want 00/00", rsp_valid, rsp_rdata);
    end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_p0();
    drive_op(0, 1'b1, 14'h0123, 8'hA5, 1'b0);
    wait_done();
  endtask

  task automatic test_read_p1();
    drive_op(1, 1'b0, 14'h0123, 8'h00, 1'b0);
    wait_done();
  endtask

  task automatic test_arbitration();
    int want[8];
`ifdef SRAM_ARB_RR_EN
    want = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    want = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) drive_op(0, 1'b0, AW'(14'h0100 + i), 8'h00, i < 3);
      end
      begin
        for (int j = 0; j < 4; j++) drive_op(1, 1'b0, AW'(14'h0180 + j), 8'h00, j < 3);
      end
    join
    wait_done();
    total++;
    if (gnt_log.size() != 8) begin
      bad++; $display("FAIL grant_count got %0d want 8", gnt_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (gnt_log[k] != want[k]) begin
          bad++; $display("FAIL grant_order idx=%0d got %0d want %0d", k, gnt_log[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    hs_log.delete();
    rsp_log.delete();
    drive_op(0, 1'b1, 14'h3FFF, 8'hFF, 1'b1);
    drive_op(0, 1'b0, 14'h3FFF, 8'h00, 1'b0);
    drive_op(1, 1'b1, 14'h0000, 8'h5A, 1'b1);
    drive_op(1, 1'b0, 14'h0000, 8'h00, 1'b0);
    wait_done();
    total++;
    if (hs_log.size() < 4 || rsp_log.size() < 4) begin
      bad++; $display("FAIL b2b_count got %0d/%0d want 4/4", hs_log.size(), rsp_log.size());
    end else begin
      total++;
      if (hs_log[1] != rsp_log[0]) begin
        bad++; $display("FAIL b2b_accept got cyc %0d want cyc %0d", hs_log[1], rsp_log[0]);
      end
      total++;
      if (hs_log[3] != rsp_log[2]) begin
        bad++; $display("FAIL b2b_accept2 got cyc %0d want cyc %0d", hs_log[3], rsp_log[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      drive_op($urandom_range(0, 1), 1'($urandom_range(0, 1)),
               AW'(14'h1000 + $urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0);
    end
    wait_done();
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    drive_op(0, 1'b1, 14'h0200, 8'h3C, 1'b0);
    while (we_n !== 1'b0 && n < 50) begin
      @(negedge clk); n++;
    end
    total++;
    if (we_n !== 1'b0) begin
      bad++; $display("FAIL abort_no_pulse got we_n=%b want 0", we_n);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    v1 = 1'b1; we1 = 1'b0; a1 = 14'h0123; d1 = 8'h00;
    exp_q.delete();
    exp_t.delete();
    ref_mem.delete(int'(14'h0200));
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL abort_ready got %b want 00", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    total++;
    if ({cs_n, we_n, dq_oe} !== 3'b110) begin
      bad++; $display("FAIL abort_pins got %b want 110", {cs_n, we_n, dq_oe});
    end
    drive_op(1, 1'b0, 14'h0123, 8'h00, 1'b0);
    wait_done();
    total++;
    if (last_rd !== 8'hA5) begin bad++; $display("FAIL abort_recover got %h want a5", last_rd); end
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p1();
    test_arbitration();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
